// File: rtl/booth_mac_acc.sv
// Frame accumulator for signed Booth products: sums N_TERMS products and hands the result
// off on a valid/ready port. Define SAT_EN for saturating arithmetic (default: wrap-around).
module booth_mac_acc #(
  parameter int unsigned ACC_W   = 12,
  parameter int unsigned N_TERMS = 4
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             clr_i,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [7:0]       p_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [ACC_W-1:0] acc_out_o,
  output logic             ovf_o
);

  localparam int unsigned     CntW    = $clog2(N_TERMS + 1);
  localparam logic [CntW-1:0] LastCnt = CntW'(N_TERMS - 1);

  typedef enum logic [0:0] {StAcc, StDone} state_e;

  state_e           state_q, state_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic [ACC_W-1:0] acc_q, acc_d;
  logic [ACC_W-1:0] acc_out_q, acc_out_d;
  logic             ovf_q, ovf_d;

  logic [ACC_W-1:0] p_ext, sum_raw, sum;
  logic             add_ovf, accept;

  assign p_ext   = ACC_W'($signed(p_i));
  assign sum_raw = acc_q + p_ext;
  // Same-sign operands whose sum flips sign is a two's-complement overflow.
  assign add_ovf = (acc_q[ACC_W-1] == p_ext[ACC_W-1]) && (sum_raw[ACC_W-1] != acc_q[ACC_W-1]);

`ifdef SAT_EN
  always_comb begin
    sum = sum_raw;
    if (add_ovf) begin
      sum = acc_q[ACC_W-1] ? {1'b1, {(ACC_W-1){1'b0}}} : {1'b0, {(ACC_W-1){1'b1}}};
    end
  end
`else
  assign sum = sum_raw;
`endif

  assign in_ready_o  = (state_q == StAcc);
  assign out_valid_o = (state_q == StDone);
  assign acc_out_o   = acc_out_q;
  assign ovf_o       = ovf_q;
  assign accept      = in_valid_i & in_ready_o;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    acc_d     = acc_q;
    acc_out_d = acc_out_q;
    ovf_d     = ovf_q;
    if (clr_i) begin
      // Abort wins over any handshake this cycle; acc_out keeps the last published frame.
      state_d = StAcc;
      cnt_d   = '0;
      acc_d   = '0;
      ovf_d   = 1'b0;
    end else begin
      unique case (state_q)
        StAcc: begin
          if (accept) begin
            acc_d = sum;
            ovf_d = ovf_q | add_ovf;
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == LastCnt) begin
              state_d   = StDone;
              acc_out_d = sum;
            end
          end
        end
        StDone: begin
          if (out_ready_i) begin
            state_d = StAcc;
            cnt_d   = '0;
            acc_d   = '0;
            ovf_d   = 1'b0;
          end
        end
        default: state_d = StAcc;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= StAcc;
      cnt_q     <= '0;
      acc_q     <= '0;
      acc_out_q <= '0;
      ovf_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      acc_q     <= acc_d;
      acc_out_q <= acc_out_d;
      ovf_q     <= ovf_d;
    end
  end

endmodule

// File: tb/tb_booth_mac_acc.sv
// Bench for booth_mac_acc: a 12-bit and an 8-bit accumulator share one stimulus stream and
// are compared every cycle against an integer-arithmetic frame model.
module tb_booth_mac_acc;

  localparam int NTerms = 4;

  logic       clk = 1'b0;
  logic       rst, clr, in_valid, out_ready;
  logic [7:0] p;

  logic        in_ready12, out_valid12, ovf12;
  logic [11:0] acc_out12;
  logic        in_ready8, out_valid8, ovf8;
  logic [7:0]  acc_out8;

  int checks   = 0;
  int failures = 0;

  // Model state; index 0 is the 12-bit instance, index 1 the 8-bit one.
  bit m_done;
  int m_cnt;
  int m_acc[2];
  int m_res[2];
  bit m_ovf[2];
  int m_wid[2] = '{12, 8};

  always #5 clk = ~clk;

  booth_mac_acc u_dut12 (
    .clk_i       (clk),
    .rst_i       (rst),
    .clr_i       (clr),
    .in_valid_i  (in_valid),
    .in_ready_o  (in_ready12),
    .p_i         (p),
    .out_valid_o (out_valid12),
    .out_ready_i (out_ready),
    .acc_out_o   (acc_out12),
    .ovf_o       (ovf12)
  );

  booth_mac_acc #(
    .ACC_W   (8),
    .N_TERMS (NTerms)
  ) u_dut8 (
    .clk_i       (clk),
    .rst_i       (rst),
    .clr_i       (clr),
    .in_valid_i  (in_valid),
    .in_ready_o  (in_ready8),
    .p_i         (p),
    .out_valid_o (out_valid8),
    .out_ready_i (out_ready),
    .acc_out_o   (acc_out8),
    .ovf_o       (ovf8)
  );

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // One signed add in a w-bit accumulator: flag overflow, then wrap or clamp.
  function automatic void model_add(input int i, input int prod);
    int lo, hi, t;
    lo = -(1 <<< (m_wid[i] - 1));
    hi = (1 <<< (m_wid[i] - 1)) - 1;
    t  = m_acc[i] + prod;
    if (t > hi || t < lo) begin
      m_ovf[i] = 1'b1;
`ifdef SAT_EN
      t = (t > hi) ? hi : lo;
`else
      t = (t > hi) ? t - (1 <<< m_wid[i]) : t + (1 <<< m_wid[i]);
`endif
    end
    m_acc[i] = t;
  endfunction

  function automatic void model_clear(input bit also_res);
    m_done = 1'b0;
    m_cnt  = 0;
    for (int i = 0; i < 2; i++) begin
      m_acc[i] = 0;
      m_ovf[i] = 1'b0;
      if (also_res) m_res[i] = 0;
    end
  endfunction

  function automatic void model_edge();
    int prod;
    prod = int'($signed(p));
    if (rst) model_clear(1'b1);
    else if (clr) model_clear(1'b0);
    else if (!m_done) begin
      if (in_valid) begin
        for (int i = 0; i < 2; i++) model_add(i, prod);
        m_cnt++;
        if (m_cnt == NTerms) begin
          m_done = 1'b1;
          for (int i = 0; i < 2; i++) m_res[i] = m_acc[i];
        end
      end
    end else if (out_ready) begin
      model_clear(1'b0);
    end
  endfunction

  task automatic check_outputs();
    check_val("in_ready_w12",  32'(in_ready12),  32'(!m_done));
    check_val("out_valid_w12", 32'(out_valid12), 32'(m_done));
    check_val("acc_out_w12",   32'(acc_out12),   32'(m_res[0]) & 32'hFFF);
    check_val("ovf_w12",       32'(ovf12),       32'(m_ovf[0]));
    check_val("in_ready_w8",   32'(in_ready8),   32'(!m_done));
    check_val("out_valid_w8",  32'(out_valid8),  32'(m_done));
    check_val("acc_out_w8",    32'(acc_out8),    32'(m_res[1]) & 32'hFF);
    check_val("ovf_w8",        32'(ovf8),        32'(m_ovf[1]));
  endtask

  // Drive inputs, let one rising edge pass, update the model, check on the falling edge.
  task automatic cycle(input logic r, input logic c, input logic iv, input logic [7:0] pv,
                       input logic ordy);
    rst       = r;
    clr       = c;
    in_valid  = iv;
    p         = pv;
    out_ready = ordy;
    @(posedge clk);
    model_edge();
    @(negedge clk);
    check_outputs();
  endtask

  task automatic feed(input logic [7:0] pv, input logic ordy);
    cycle(1'b0, 1'b0, 1'b1, pv, ordy);
  endtask

  task automatic drain();
    cycle(1'b0, 1'b0, 1'b0, 8'h00, 1'b1);
  endtask

  initial begin
    logic [7:0] basic [4];
    basic = '{8'h06, 8'hF7, 8'h31, 8'h80};
    model_clear(1'b1);

    // Reset held with a product presented: nothing may be absorbed.
    cycle(1'b1, 1'b0, 1'b1, 8'h55, 1'b0);
    cycle(1'b1, 1'b0, 1'b1, 8'h55, 1'b0);
    drain();
    check_val("reset_acc_out", 32'(acc_out12), 32'h0);

    // Basic frame: 6 - 9 + 49 - 128 = -82.
    for (int i = 0; i < 4; i++) feed(basic[i], 1'b1);
    check_val("basic_valid", 32'(out_valid12), 32'h1);
    check_val("basic_sum",   32'(acc_out12),   32'hFAE);
    check_val("basic_ovf",   32'(ovf12),       32'h0);
    drain();
    check_val("basic_ready_after", 32'(in_ready12), 32'h1);

    // Backpressure: result held, products ignored while pending.
    for (int i = 0; i < 4; i++) feed(8'h01, 1'b0);
    for (int i = 0; i < 5; i++) feed(8'h01, 1'b0);
    check_val("bp_in_ready", 32'(in_ready12), 32'h0);
    check_val("bp_hold",     32'(acc_out12),  32'h004);
    drain();
    for (int i = 0; i < 4; i++) feed(8'h01, 1'b0);
    check_val("bp_next_frame", 32'(acc_out12), 32'h004);
    drain();

    // Overflow in the 8-bit instance: 4 x 127.
    for (int i = 0; i < 4; i++) feed(8'h7F, 1'b0);
`ifdef SAT_EN
    check_val("ovf_sum_w8", 32'(acc_out8), 32'h7F);
`else
    check_val("ovf_sum_w8", 32'(acc_out8), 32'hFC);
`endif
    check_val("ovf_flag_w8",  32'(ovf8),      32'h1);
    check_val("ovf_sum_w12",  32'(acc_out12), 32'h1FC);
    drain();
    for (int i = 0; i < 4; i++) feed(8'h00, 1'b0);
    check_val("ovf_clear_sum",  32'(acc_out8), 32'h0);
    check_val("ovf_clear_flag", 32'(ovf8),     32'h0);
    drain();

    // clr mid-frame drops the product presented with it.
    feed(8'h10, 1'b0);
    feed(8'h20, 1'b0);
    cycle(1'b0, 1'b1, 1'b1, 8'h40, 1'b0);
    for (int i = 0; i < 4; i++) feed(8'h01, 1'b0);
    check_val("clr_sum", 32'(acc_out12), 32'h004);
    drain();

    // Gapped input of four -1 products.
    for (int i = 0; i < 4; i++) begin
      for (int g = 0; g < i; g++) cycle(1'b0, 1'b0, 1'b0, 8'hAA, 1'b0);
      feed(8'hFF, 1'b0);
    end
    check_val("gap_valid", 32'(out_valid12), 32'h1);
    check_val("gap_sum",   32'(acc_out12),   32'hFFC);
    drain();

    // Randomized traffic, including occasional clr and rst.
    for (int n = 0; n < 600; n++) begin
      cycle(logic'($urandom_range(99) == 0), logic'($urandom_range(29) == 0),
            logic'($urandom_range(9) < 7), 8'($urandom), logic'($urandom_range(1)));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
